// File: rtl/frame_pixel_assembler_if.sv
// Byte stream channel feeding the frame pixel assembler.
// sof marks byte 0 of pixel (0,0) and is qualified by the byte handshake.
interface frame_pixel_assembler_if;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;
    logic       sof;

    modport master (output byte_in, output byte_valid, output sof, input byte_ready);
    modport slave  (input byte_in, input byte_valid, input sof, output byte_ready);
endinterface

// File: rtl/frame_pixel_assembler.sv
// Packs a byte stream into pixels and writes them into an H_RES x V_RES store,
// with a zero-fill sweep, start-of-frame resync and a registered read port.
module frame_pixel_assembler #(
    parameter int H_RES        = 100,
    parameter int V_RES        = 100,
    parameter int BYTES_PER_PX = 3,
    parameter int MERGE        = 0,
    localparam int PX_W = 8 * BYTES_PER_PX,
    localparam int XW   = (H_RES > 1) ? $clog2(H_RES) : 1,
    localparam int YW   = (V_RES > 1) ? $clog2(V_RES) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    frame_pixel_assembler_if.slave s_bus,
    input  logic                   i_clear_req,
    output logic                   o_clear_busy,
    output logic                   o_frame_done,
    output logic                   o_sync_err,
    input  logic                   i_rd_en,
    input  logic [XW-1:0]          i_rd_x,
    input  logic [YW-1:0]          i_rd_y,
    output logic [PX_W-1:0]        o_rd_data,
    output logic                   o_rd_valid
);
    localparam int DEPTH = H_RES * V_RES;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IW    = (BYTES_PER_PX > 1) ? $clog2(BYTES_PER_PX) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [XW-1:0] X_LAST    = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_LAST    = YW'(V_RES - 1);
    localparam logic [IW-1:0] I_LAST    = IW'(BYTES_PER_PX - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            r_state;
    logic [AW-1:0]     r_sweepAddr;
    logic [XW-1:0]     r_x;
    logic [YW-1:0]     r_y;
    logic [IW-1:0]     r_byteIdx;
    logic [PX_W-1:0]   r_partial;
    logic              r_frameDone;
    logic              r_syncErr;
    logic              r_rdValid;
    logic [PX_W-1:0]   r_rdData;
    logic [PX_W-1:0]   r_mem [DEPTH];

    state_t            w_nextState;
    logic [AW-1:0]     w_nextSweep;
    logic [XW-1:0]     w_nextX;
    logic [YW-1:0]     w_nextY;
    logic [IW-1:0]     w_nextIdx;
    logic [PX_W-1:0]   w_nextPartial;
    logic              w_frameDone;
    logic              w_syncErr;
    logic [IW-1:0]     w_effIdx;
    logic [XW-1:0]     w_curX;
    logic [YW-1:0]     w_curY;
    logic [PX_W-1:0]   w_pixel;
    logic [AW-1:0]     w_pixAddr;
    logic              w_memWe;
    logic [AW-1:0]     w_memAddr;
    logic [PX_W-1:0]   w_memData;
    logic              w_rdInRange;
    logic [AW-1:0]     w_rdAddr;

    assign s_bus.byte_ready = (r_state == RUN) && !i_clear_req;
    assign o_clear_busy     = (r_state == CLEAR);
    assign o_frame_done     = r_frameDone;
    assign o_sync_err       = r_syncErr;
    assign o_rd_valid       = r_rdValid;
    assign o_rd_data        = r_rdData;

    // A sof byte restarts the pixel at (0,0) regardless of where the tracker was.
    always_comb begin
        w_nextState   = r_state;
        w_nextSweep   = '0;
        w_nextX       = r_x;
        w_nextY       = r_y;
        w_nextIdx     = r_byteIdx;
        w_nextPartial = r_partial;
        w_frameDone   = 1'b0;
        w_syncErr     = 1'b0;
        w_memWe       = 1'b0;
        w_memAddr     = r_sweepAddr;
        w_memData     = '0;
        w_effIdx      = s_bus.sof ? '0 : r_byteIdx;
        w_curX        = s_bus.sof ? '0 : r_x;
        w_curY        = s_bus.sof ? '0 : r_y;
        w_pixAddr     = AW'(int'(w_curY) * H_RES + int'(w_curX));
        w_pixel       = s_bus.sof ? '0 : r_partial;
        for (int k = 0; k < BYTES_PER_PX; k++) begin
            if (IW'(k) == w_effIdx) w_pixel[8*k +: 8] = s_bus.byte_in;
        end
        case (r_state)
            CLEAR: begin
                w_memWe       = 1'b1;
                w_nextX       = '0;
                w_nextY       = '0;
                w_nextIdx     = '0;
                w_nextPartial = '0;
                if (r_sweepAddr == LAST_ADDR) w_nextState = RUN;
                else                          w_nextSweep = r_sweepAddr + AW'(1);
            end
            RUN: begin
                if (i_clear_req) begin
                    w_nextState   = CLEAR;
                    w_nextX       = '0;
                    w_nextY       = '0;
                    w_nextIdx     = '0;
                    w_nextPartial = '0;
                end else if (s_bus.byte_valid) begin
                    w_syncErr = s_bus.sof && (r_byteIdx != '0 || r_x != '0 || r_y != '0);
                    if (w_effIdx == I_LAST) begin
                        w_memWe       = 1'b1;
                        w_memAddr     = w_pixAddr;
                        w_memData     = (MERGE != 0) ? (r_mem[w_pixAddr] | w_pixel) : w_pixel;
                        w_nextIdx     = '0;
                        w_nextPartial = '0;
                        if (w_curX == X_LAST) begin
                            w_nextX = '0;
                            if (w_curY == Y_LAST) begin
                                w_nextY     = '0;
                                w_frameDone = 1'b1;
                            end else begin
                                w_nextY = w_curY + YW'(1);
                            end
                        end else begin
                            w_nextX = w_curX + XW'(1);
                            w_nextY = w_curY;
                        end
                    end else begin
                        w_nextIdx     = w_effIdx + IW'(1);
                        w_nextPartial = w_pixel;
                        w_nextX       = w_curX;
                        w_nextY       = w_curY;
                    end
                end
            end
            default: w_nextState = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= CLEAR;
            r_sweepAddr <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_byteIdx   <= '0;
            r_partial   <= '0;
            r_frameDone <= 1'b0;
            r_syncErr   <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_sweepAddr <= w_nextSweep;
            r_x         <= w_nextX;
            r_y         <= w_nextY;
            r_byteIdx   <= w_nextIdx;
            r_partial   <= w_nextPartial;
            r_frameDone <= w_frameDone;
            r_syncErr   <= w_syncErr;
        end
    end

    // Store contents are deliberately not reset; the sweep zeroes them.
    always_ff @(posedge clk) begin
        if (w_memWe) r_mem[w_memAddr] <= w_memData;
    end

    assign w_rdInRange = (int'(i_rd_x) < H_RES) && (int'(i_rd_y) < V_RES);
    assign w_rdAddr    = AW'(int'(i_rd_y) * H_RES + int'(i_rd_x));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdValid <= 1'b0;
            r_rdData  <= '0;
        end else begin
            r_rdValid <= i_rd_en;
            if (i_rd_en) r_rdData <= w_rdInRange ? r_mem[w_rdAddr] : '0;
        end
    end
endmodule

// File: tb/tb_frame_pixel_assembler.sv
// Directed bench for frame_pixel_assembler: a 4x2, 3-byte overwrite instance
// and a 4x2, 3-byte OR-merge instance driven from one sequence of scenario tasks.
module tb_frame_pixel_assembler;
    logic        clk = 1'b0;
    logic        reset;
    logic        clr0, clr1, busy0, busy1, fd0, fd1, se0, se1;
    logic        rdEn0, rdEn1, rdValid0, rdValid1;
    logic [1:0]  rdX0, rdX1;
    logic [0:0]  rdY0, rdY1;
    logic [23:0] rdData0, rdData1;
    int          nChecks, nFails;

    frame_pixel_assembler_if bus0();
    frame_pixel_assembler_if bus1();

    frame_pixel_assembler #(.H_RES(4), .V_RES(2), .BYTES_PER_PX(3), .MERGE(0)) dut0 (
        .clk(clk), .reset(reset), .s_bus(bus0), .i_clear_req(clr0), .o_clear_busy(busy0),
        .o_frame_done(fd0), .o_sync_err(se0), .i_rd_en(rdEn0), .i_rd_x(rdX0), .i_rd_y(rdY0),
        .o_rd_data(rdData0), .o_rd_valid(rdValid0));

    frame_pixel_assembler #(.H_RES(4), .V_RES(2), .BYTES_PER_PX(3), .MERGE(1)) dut1 (
        .clk(clk), .reset(reset), .s_bus(bus1), .i_clear_req(clr1), .o_clear_busy(busy1),
        .o_frame_done(fd1), .o_sync_err(se1), .i_rd_en(rdEn1), .i_rd_x(rdX1), .i_rd_y(rdY1),
        .o_rd_data(rdData1), .o_rd_valid(rdValid1));

    always #5 clk = ~clk;

    // Offers one byte on the chosen instance for exactly one rising edge.
    task automatic applyStimulus(input int sel, input logic [7:0] b, input logic s);
        @(negedge clk);
        if (sel == 0) begin bus0.byte_in = b; bus0.sof = s; bus0.byte_valid = 1'b1; end
        else          begin bus1.byte_in = b; bus1.sof = s; bus1.byte_valid = 1'b1; end
        @(posedge clk); #1;
        bus0.byte_valid = 1'b0; bus0.sof = 1'b0;
        bus1.byte_valid = 1'b0; bus1.sof = 1'b0;
    endtask

    task automatic readPixel(input int sel, input int x, input int y,
                             output logic [23:0] data, output logic valid);
        @(negedge clk);
        if (sel == 0) begin rdEn0 = 1'b1; rdX0 = 2'(x); rdY0 = 1'(y); end
        else          begin rdEn1 = 1'b1; rdX1 = 2'(x); rdY1 = 1'(y); end
        @(posedge clk); #1;
        data  = (sel == 0) ? rdData0 : rdData1;
        valid = (sel == 0) ? rdValid0 : rdValid1;
        rdEn0 = 1'b0; rdEn1 = 1'b0;
    endtask

    task automatic test_reset;
        logic [23:0] d;
        logic        v;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nChecks++; if (bus0.byte_ready !== 1'b0) begin nFails++; $display("[TB] FAIL reset_ready got %b want 0", bus0.byte_ready); end
        nChecks++; if (busy0 !== 1'b1) begin nFails++; $display("[TB] FAIL reset_busy got %b want 1", busy0); end
        nChecks++; if (fd0 !== 1'b0 || se0 !== 1'b0) begin nFails++; $display("[TB] FAIL reset_pulses got fd=%b se=%b want 0 0", fd0, se0); end
        nChecks++; if (rdValid0 !== 1'b0 || rdData0 !== 24'h0) begin nFails++; $display("[TB] FAIL reset_rd got v=%b d=%h want 0 000000", rdValid0, rdData0); end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            nChecks++;
            if (bus0.byte_ready !== (i == 8)) begin nFails++; $display("[TB] FAIL ready_rise cycle %0d got %b want %b", i, bus0.byte_ready, (i == 8)); end
        end
        for (int a = 0; a < 8; a++) begin
            readPixel(0, a % 4, a / 4, d, v);
            nChecks++;
            if (d !== 24'h0 || v !== 1'b1) begin nFails++; $display("[TB] FAIL cleared_px %0d got v=%b d=%h want 1 000000", a, v, d); end
        end
    endtask

    task automatic test_single_pixel;
        logic [23:0] d;
        logic        v;
        applyStimulus(0, 8'h01, 1'b1);
        nChecks++; if (se0 !== 1'b0) begin nFails++; $display("[TB] FAIL aligned_sof_err got %b want 0", se0); end
        applyStimulus(0, 8'h02, 1'b0);
        applyStimulus(0, 8'h03, 1'b0);
        nChecks++; if (fd0 !== 1'b0) begin nFails++; $display("[TB] FAIL early_frame_done got %b want 0", fd0); end
        readPixel(0, 0, 0, d, v);
        nChecks++; if (d !== 24'h030201 || v !== 1'b1) begin nFails++; $display("[TB] FAIL px00 got v=%b d=%h want 1 030201", v, d); end
    endtask

    task automatic test_full_frame;
        logic [23:0] d;
        logic        v;
        for (int b = 4; b <= 24; b++) begin
            applyStimulus(0, 8'(b), 1'b0);
            if (b == 23) begin
                nChecks++; if (fd0 !== 1'b0) begin nFails++; $display("[TB] FAIL fd_byte23 got %b want 0", fd0); end
            end
            if (b == 24) begin
                nChecks++; if (fd0 !== 1'b1) begin nFails++; $display("[TB] FAIL fd_byte24 got %b want 1", fd0); end
            end
        end
        @(posedge clk); #1;
        nChecks++; if (fd0 !== 1'b0) begin nFails++; $display("[TB] FAIL fd_width got %b want 0", fd0); end
        readPixel(0, 3, 1, d, v);
        nChecks++; if (d !== 24'h181716) begin nFails++; $display("[TB] FAIL px31 got %h want 181716", d); end
        readPixel(0, 1, 0, d, v);
        nChecks++; if (d !== 24'h060504) begin nFails++; $display("[TB] FAIL px10 got %h want 060504", d); end
        applyStimulus(0, 8'h31, 1'b0);
        applyStimulus(0, 8'h32, 1'b0);
        applyStimulus(0, 8'h33, 1'b0);
        readPixel(0, 0, 0, d, v);
        nChecks++; if (d !== 24'h333231) begin nFails++; $display("[TB] FAIL wrap_px00 got %h want 333231", d); end
    endtask

    task automatic test_sync_err;
        logic [23:0] d;
        logic        v;
        applyStimulus(0, 8'h11, 1'b0);
        applyStimulus(0, 8'h22, 1'b0);
        applyStimulus(0, 8'hAA, 1'b1);
        nChecks++; if (se0 !== 1'b1) begin nFails++; $display("[TB] FAIL sync_err_pulse got %b want 1", se0); end
        applyStimulus(0, 8'hBB, 1'b0);
        nChecks++; if (se0 !== 1'b0) begin nFails++; $display("[TB] FAIL sync_err_width got %b want 0", se0); end
        // Last byte and a read of the same address share one edge.
        @(negedge clk);
        bus0.byte_in = 8'hCC; bus0.byte_valid = 1'b1; rdEn0 = 1'b1; rdX0 = 2'd0; rdY0 = 1'd0;
        @(posedge clk); #1;
        bus0.byte_valid = 1'b0; rdEn0 = 1'b0;
        nChecks++; if (rdData0 !== 24'h333231) begin nFails++; $display("[TB] FAIL rw_same_addr got %h want 333231", rdData0); end
        readPixel(0, 0, 0, d, v);
        nChecks++; if (d !== 24'hCCBBAA) begin nFails++; $display("[TB] FAIL resync_px00 got %h want ccbbaa", d); end
        readPixel(0, 1, 0, d, v);
        nChecks++; if (d !== 24'h060504) begin nFails++; $display("[TB] FAIL partial_dropped got %h want 060504", d); end
    endtask

    task automatic test_read_hold;
        @(posedge clk); #1;
        nChecks++; if (rdValid0 !== 1'b0 || rdData0 !== 24'h060504) begin nFails++; $display("[TB] FAIL rd_hold got v=%b d=%h want 0 060504", rdValid0, rdData0); end
    endtask

    task automatic test_clear;
        logic [23:0] d;
        logic        v;
        @(negedge clk);
        clr0 = 1'b1; bus0.byte_in = 8'hEE; bus0.byte_valid = 1'b1;
        #1;
        nChecks++; if (bus0.byte_ready !== 1'b0) begin nFails++; $display("[TB] FAIL clr_ready got %b want 0", bus0.byte_ready); end
        @(posedge clk); #1;
        bus0.byte_valid = 1'b0;
        nChecks++; if (busy0 !== 1'b1) begin nFails++; $display("[TB] FAIL clr_enter got %b want 1", busy0); end
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            nChecks++;
            if (busy0 !== (i < 8)) begin nFails++; $display("[TB] FAIL clr_busy cycle %0d got %b want %b", i, busy0, (i < 8)); end
            if (i == 3) clr0 = 1'b0;
        end
        readPixel(0, 0, 0, d, v);
        nChecks++; if (d !== 24'h0) begin nFails++; $display("[TB] FAIL clr_px00 got %h want 000000", d); end
        readPixel(0, 3, 1, d, v);
        nChecks++; if (d !== 24'h0) begin nFails++; $display("[TB] FAIL clr_px31 got %h want 000000", d); end
        applyStimulus(0, 8'h41, 1'b0);
        applyStimulus(0, 8'h42, 1'b0);
        applyStimulus(0, 8'h43, 1'b0);
        readPixel(0, 0, 0, d, v);
        nChecks++; if (d !== 24'h434241) begin nFails++; $display("[TB] FAIL post_clr_px00 got %h want 434241", d); end
    endtask

    task automatic test_merge;
        logic [23:0] d;
        logic        v;
        applyStimulus(1, 8'hF0, 1'b1);
        for (int b = 2; b <= 24; b++) applyStimulus(1, 8'h00, 1'b0);
        nChecks++; if (fd1 !== 1'b1) begin nFails++; $display("[TB] FAIL merge_fd got %b want 1", fd1); end
        applyStimulus(1, 8'h0F, 1'b1);
        nChecks++; if (se1 !== 1'b0) begin nFails++; $display("[TB] FAIL merge_sof_err got %b want 0", se1); end
        applyStimulus(1, 8'h00, 1'b0);
        applyStimulus(1, 8'h00, 1'b0);
        readPixel(1, 0, 0, d, v);
        nChecks++; if (d !== 24'h0000FF) begin nFails++; $display("[TB] FAIL merge_px00 got %h want 0000ff", d); end
        @(negedge clk); clr1 = 1'b1;
        @(posedge clk); #1; clr1 = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            nChecks++;
            if (busy1 !== (i < 8)) begin nFails++; $display("[TB] FAIL merge_busy cycle %0d got %b want %b", i, busy1, (i < 8)); end
        end
        readPixel(1, 0, 0, d, v);
        nChecks++; if (d !== 24'h0) begin nFails++; $display("[TB] FAIL merge_clr_px00 got %h want 000000", d); end
    endtask

    task automatic test_reset_mid;
        logic [23:0] d;
        logic        v;
        applyStimulus(0, 8'h77, 1'b0);
        applyStimulus(0, 8'h88, 1'b0);
        applyStimulus(0, 8'h99, 1'b0);
        readPixel(0, 1, 0, d, v);
        nChecks++; if (d !== 24'h998877) begin nFails++; $display("[TB] FAIL px10_pre_rst got %h want 998877", d); end
        applyStimulus(0, 8'h55, 1'b0);
        @(negedge clk); reset = 1'b0; #1;
        nChecks++; if (bus0.byte_ready !== 1'b0 || busy0 !== 1'b1) begin nFails++; $display("[TB] FAIL rst_mid_ctrl got rdy=%b busy=%b want 0 1", bus0.byte_ready, busy0); end
        nChecks++; if (rdData0 !== 24'h0 || rdValid0 !== 1'b0 || fd0 !== 1'b0 || se0 !== 1'b0) begin nFails++; $display("[TB] FAIL rst_mid_out got d=%h v=%b fd=%b se=%b want 000000 0 0 0", rdData0, rdValid0, fd0, se0); end
        @(negedge clk); reset = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk); reset = 1'b0; #1;
        nChecks++; if (bus0.byte_ready !== 1'b0 || busy0 !== 1'b1) begin nFails++; $display("[TB] FAIL rst_sweep_ctrl got rdy=%b busy=%b want 0 1", bus0.byte_ready, busy0); end
        @(negedge clk); reset = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            nChecks++;
            if (bus0.byte_ready !== (i == 8)) begin nFails++; $display("[TB] FAIL resweep_ready cycle %0d got %b want %b", i, bus0.byte_ready, (i == 8)); end
        end
        applyStimulus(0, 8'h01, 1'b0);
        applyStimulus(0, 8'h02, 1'b0);
        applyStimulus(0, 8'h03, 1'b0);
        nChecks++; if (se0 !== 1'b0) begin nFails++; $display("[TB] FAIL resume_err got %b want 0", se0); end
        readPixel(0, 0, 0, d, v);
        nChecks++; if (d !== 24'h030201) begin nFails++; $display("[TB] FAIL resume_px00 got %h want 030201", d); end
        readPixel(0, 1, 0, d, v);
        nChecks++; if (d !== 24'h0) begin nFails++; $display("[TB] FAIL resume_px10 got %h want 000000", d); end
    endtask

    initial begin
        nChecks = 0; nFails = 0;
        reset = 1'b0;
        bus0.byte_in = 8'h0; bus0.byte_valid = 1'b0; bus0.sof = 1'b0;
        bus1.byte_in = 8'h0; bus1.byte_valid = 1'b0; bus1.sof = 1'b0;
        clr0 = 1'b0; clr1 = 1'b0;
        rdEn0 = 1'b0; rdEn1 = 1'b0; rdX0 = 2'd0; rdX1 = 2'd0; rdY0 = 1'd0; rdY1 = 1'd0;
        test_reset;
        test_single_pixel;
        test_full_frame;
        test_sync_err;
        test_read_hold;
        test_clear;
        test_merge;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
